// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator with retrigger, free, busy and steal priorities
module voice_allocator #(
  parameter int NVOICES = 8,
  parameter int AGE_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_cmd_valid,
  input  logic [15:0]                i_cmd_data,
  output logic                       o_cmd_ready,
  output logic                       o_voice_wr,
  output logic [$clog2(NVOICES)-1:0] o_voice_idx,
  output logic [6:0]                 o_voice_note,
  output logic [6:0]                 o_voice_vel,
  output logic                       o_voice_gate,
  input  logic [NVOICES-1:0]         i_voice_busy,
  output logic [NVOICES-1:0]         o_active_mask,
  output logic                       o_steal,
  output logic                       o_drop
);
  localparam int IDX_W = $clog2(NVOICES);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   scan_q, scan_d;
  logic               cmd_on_q, cmd_on_d;
  logic [6:0]         cmd_note_q, cmd_note_d;
  logic [6:0]         cmd_vel_q, cmd_vel_d;

  // Running best candidate per priority class, built up one voice per scan cycle.
  logic               rt_hit_q, rt_hit_d;
  logic [IDX_W-1:0]   rt_idx_q, rt_idx_d;
  logic               fr_hit_q, fr_hit_d;
  logic [IDX_W-1:0]   fr_idx_q, fr_idx_d;
  logic               bz_hit_q, bz_hit_d;
  logic [IDX_W-1:0]   bz_idx_q, bz_idx_d;
  logic               st_hit_q, st_hit_d;
  logic [IDX_W-1:0]   st_idx_q, st_idx_d;
  logic [AGE_W-1:0]   st_age_q, st_age_d;

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [6:0]         onote_q, onote_d;
  logic [6:0]         ovel_q, ovel_d;
  logic               ogate_q, ogate_d;
  logic               steal_q, steal_d;
  logic               drop_q, drop_d;

  logic [NVOICES-1:0] gate_q, gate_d;
  logic [6:0]         note_q [NVOICES];
  logic [6:0]         note_d [NVOICES];
  logic [AGE_W-1:0]   age_q [NVOICES];
  logic [AGE_W-1:0]   age_d [NVOICES];

  logic               cmd_unused;
  logic               cur_gate;
  logic               cur_same;

  assign cmd_unused    = i_cmd_data[7];
  assign o_cmd_ready   = (state_q == IDLE);
  assign o_voice_wr    = (state_q == ISSUE);
  assign o_voice_idx   = idx_q;
  assign o_voice_note  = onote_q;
  assign o_voice_vel   = ovel_q;
  assign o_voice_gate  = ogate_q;
  assign o_steal       = steal_q;
  assign o_drop        = drop_q;
  assign o_active_mask = gate_q;
  assign cur_gate      = gate_q[scan_q];
  assign cur_same      = cur_gate && (note_q[scan_q] == cmd_note_q);

  // Next-state, candidate search and table update.
  always_comb begin
    state_d    = state_q;
    scan_d     = scan_q;
    cmd_on_d   = cmd_on_q;
    cmd_note_d = cmd_note_q;
    cmd_vel_d  = cmd_vel_q;
    rt_hit_d   = rt_hit_q;
    rt_idx_d   = rt_idx_q;
    fr_hit_d   = fr_hit_q;
    fr_idx_d   = fr_idx_q;
    bz_hit_d   = bz_hit_q;
    bz_idx_d   = bz_idx_q;
    st_hit_d   = st_hit_q;
    st_idx_d   = st_idx_q;
    st_age_d   = st_age_q;
    idx_d      = idx_q;
    onote_d    = onote_q;
    ovel_d     = ovel_q;
    ogate_d    = ogate_q;
    steal_d    = 1'b0;
    drop_d     = 1'b0;
    gate_d     = gate_q;
    note_d     = note_q;
    age_d      = age_q;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          // A zero-velocity note-on is folded into a note-off here.
          cmd_on_d   = i_cmd_data[15] && (i_cmd_data[14:8] != 7'd0);
          cmd_note_d = i_cmd_data[6:0];
          cmd_vel_d  = i_cmd_data[14:8];
          scan_d     = '0;
          rt_hit_d   = 1'b0;
          fr_hit_d   = 1'b0;
          bz_hit_d   = 1'b0;
          st_hit_d   = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (cur_same && !rt_hit_q) begin
          rt_hit_d = 1'b1;
          rt_idx_d = scan_q;
        end
        if (!cur_gate && !i_voice_busy[scan_q] && !fr_hit_q) begin
          fr_hit_d = 1'b1;
          fr_idx_d = scan_q;
        end
        if (!cur_gate && i_voice_busy[scan_q] && !bz_hit_q) begin
          bz_hit_d = 1'b1;
          bz_idx_d = scan_q;
        end
        // Strictly-greater keeps the lowest index on age ties.
        if (cur_gate && (!st_hit_q || (age_q[scan_q] > st_age_q))) begin
          st_hit_d = 1'b1;
          st_idx_d = scan_q;
          st_age_d = age_q[scan_q];
        end
        scan_d = scan_q + IDX_W'(1);
        if (scan_q == IDX_W'(NVOICES - 1)) begin
          onote_d = cmd_note_q;
          if (cmd_on_q) begin
            state_d = ISSUE;
            ogate_d = 1'b1;
            ovel_d  = cmd_vel_q;
            if (rt_hit_d)      idx_d = rt_idx_d;
            else if (fr_hit_d) idx_d = fr_idx_d;
            else if (bz_hit_d) idx_d = bz_idx_d;
            else begin
              idx_d   = st_idx_d;
              steal_d = 1'b1;
            end
          end else if (rt_hit_d) begin
            state_d = ISSUE;
            ogate_d = 1'b0;
            ovel_d  = 7'd0;
            idx_d   = rt_idx_d;
          end else begin
            onote_d = onote_q;
            drop_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ISSUE: begin
        state_d = IDLE;
        if (ogate_q) begin
          for (int i = 0; i < NVOICES; i++) begin
            if (IDX_W'(i) == idx_q) begin
              gate_d[i] = 1'b1;
              note_d[i] = onote_q;
              age_d[i]  = '0;
            end else if (gate_q[i] && (age_q[i] != {AGE_W{1'b1}})) begin
              age_d[i] = age_q[i] + AGE_W'(1);
            end
          end
        end else begin
          gate_d[idx_q] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, candidate, output and table registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      scan_q     <= '0;
      cmd_on_q   <= 1'b0;
      cmd_note_q <= '0;
      cmd_vel_q  <= '0;
      rt_hit_q   <= 1'b0;
      rt_idx_q   <= '0;
      fr_hit_q   <= 1'b0;
      fr_idx_q   <= '0;
      bz_hit_q   <= 1'b0;
      bz_idx_q   <= '0;
      st_hit_q   <= 1'b0;
      st_idx_q   <= '0;
      st_age_q   <= '0;
      idx_q      <= '0;
      onote_q    <= '0;
      ovel_q     <= '0;
      ogate_q    <= 1'b0;
      steal_q    <= 1'b0;
      drop_q     <= 1'b0;
      gate_q     <= '0;
      for (int i = 0; i < NVOICES; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      scan_q     <= scan_d;
      cmd_on_q   <= cmd_on_d;
      cmd_note_q <= cmd_note_d;
      cmd_vel_q  <= cmd_vel_d;
      rt_hit_q   <= rt_hit_d;
      rt_idx_q   <= rt_idx_d;
      fr_hit_q   <= fr_hit_d;
      fr_idx_q   <= fr_idx_d;
      bz_hit_q   <= bz_hit_d;
      bz_idx_q   <= bz_idx_d;
      st_hit_q   <= st_hit_d;
      st_idx_q   <= st_idx_d;
      st_age_q   <= st_age_d;
      idx_q      <= idx_d;
      onote_q    <= onote_d;
      ovel_q     <= ovel_d;
      ogate_q    <= ogate_d;
      steal_q    <= steal_d;
      drop_q     <= drop_d;
      gate_q     <= gate_d;
      note_q     <= note_d;
      age_q      <= age_d;
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator
module tb_voice_allocator;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic [15:0] i_cmd_data = '0;
  logic       o_cmd_ready;
  logic       o_voice_wr;
  logic [2:0] o_voice_idx;
  logic [6:0] o_voice_note;
  logic [6:0] o_voice_vel;
  logic       o_voice_gate;
  logic [7:0] i_voice_busy = '0;
  logic [7:0] o_active_mask;
  logic       o_steal;
  logic       o_drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit         drop;
    logic [2:0] idx;
    logic [6:0] note;
    logic [6:0] vel;
    logic       gate;
    logic       steal;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  voice_allocator #(.NVOICES(8), .AGE_W(8)) dut (
    .clk(clk), .reset(reset),
    .i_cmd_valid(i_cmd_valid), .i_cmd_data(i_cmd_data), .o_cmd_ready(o_cmd_ready),
    .o_voice_wr(o_voice_wr), .o_voice_idx(o_voice_idx), .o_voice_note(o_voice_note),
    .o_voice_vel(o_voice_vel), .o_voice_gate(o_voice_gate), .i_voice_busy(i_voice_busy),
    .o_active_mask(o_active_mask), .o_steal(o_steal), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe or drop pulse pops one expectation.
  always @(negedge clk) begin
    if (!reset && (o_voice_wr || o_drop)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: wr=%0b drop=%0b idx=%0d with no expectation", o_voice_wr, o_drop, o_voice_idx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("event_kind_drop", {31'd0, o_drop}, {31'd0, e.drop});
        chk("event_cycle", cyc, e.cyc);
        if (!e.drop) begin
          chk("wr_idx", {29'd0, o_voice_idx}, {29'd0, e.idx});
          chk("wr_note", {25'd0, o_voice_note}, {25'd0, e.note});
          chk("wr_vel", {25'd0, o_voice_vel}, {25'd0, e.vel});
          chk("wr_gate", {31'd0, o_voice_gate}, {31'd0, e.gate});
          chk("wr_steal", {31'd0, o_steal}, {31'd0, e.steal});
        end
      end
    end
  end

  task automatic check_reset_state();
    chk("rst_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("rst_wr", {31'd0, o_voice_wr}, 32'd0);
    chk("rst_steal", {31'd0, o_steal}, 32'd0);
    chk("rst_drop", {31'd0, o_drop}, 32'd0);
    chk("rst_idx", {29'd0, o_voice_idx}, 32'd0);
    chk("rst_note", {25'd0, o_voice_note}, 32'd0);
    chk("rst_vel", {25'd0, o_voice_vel}, 32'd0);
    chk("rst_gate", {31'd0, o_voice_gate}, 32'd0);
    chk("rst_mask", {24'd0, o_active_mask}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state();
  endtask

  // Issue one command (cycle 0 = the accepting edge) and queue its expected result.
  task automatic send(input logic [15:0] d, input bit drop, input logic [2:0] idx,
                      input logic [6:0] note, input logic [6:0] vel, input logic gate,
                      input logic steal, input logic [7:0] mask);
    exp_t e;
    int c0;
    int n;
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_data  = d;
    @(posedge clk);
    #1;
    c0 = cyc - 1;
    i_cmd_valid = 1'b0;
    e.drop = drop; e.idx = idx; e.note = note; e.vel = vel;
    e.gate = gate; e.steal = steal; e.cyc = c0 + 9;
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    while (!o_cmd_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("ready_cycle", cyc - c0, drop ? 32'd9 : 32'd10);
    chk("active_mask", {24'd0, o_active_mask}, {24'd0, mask});
    if (!drop) chk("hold_idx", {29'd0, o_voice_idx}, {29'd0, idx});
  endtask

  // Accept a command, then assert reset in the given cycle of its processing.
  task automatic abort_at(input logic [15:0] d, input int rst_cycle);
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_data  = d;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    repeat (rst_cycle - 1) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    @(negedge clk);
    check_reset_state();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    @(negedge clk);
    check_reset_state();

    send(16'hC03C, 0, 3'd0, 7'd60, 7'd64, 1'b1, 1'b0, 8'h01);
    send(16'h403C, 0, 3'd0, 7'd60, 7'd0,  1'b0, 1'b0, 8'h00);
    send(16'h003D, 1, 3'd0, 7'd0,  7'd0,  1'b0, 1'b0, 8'h00);
    i_voice_busy = 8'h01;
    send(16'hE43E, 0, 3'd1, 7'd62, 7'd100, 1'b1, 1'b0, 8'h02);
    send(16'h903E, 0, 3'd1, 7'd62, 7'd16, 1'b1, 1'b0, 8'h02);
    send(16'h803E, 0, 3'd1, 7'd62, 7'd0,  1'b0, 1'b0, 8'h00);
    i_voice_busy = 8'hFF;
    send(16'hC03F, 0, 3'd0, 7'd63, 7'd64, 1'b1, 1'b0, 8'h01);
    i_voice_busy = 8'h00;

    do_reset();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] m;
      m = 8'hFF >> (7 - k);
      send(16'hC03C + 16'(k), 0, 3'(k), 7'(60 + k), 7'd64, 1'b1, 1'b0, m);
    end
    send(16'hC046, 0, 3'd0, 7'd70, 7'd64, 1'b1, 1'b1, 8'hFF);
    send(16'hC047, 0, 3'd1, 7'd71, 7'd64, 1'b1, 1'b1, 8'hFF);

    abort_at(16'hC03C, 5);
    abort_at(16'hC03C, 9);

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
